// File: rtl/fetch_ctrl_pkg.sv
// Shared front-end constants, fetch FSM encoding and PC increment helper for fetch_ctrl.
package fetch_ctrl_pkg;

  localparam int MEMI_SIZE_LOG    = 8;
  localparam int MEMI_SIZE        = 1 << MEMI_SIZE_LOG;
  localparam int INST_LEN         = 32;
  localparam int FQ_DEPTH_DEFAULT = 4;

  typedef enum logic {
    FETCH_ST_RUN  = 1'b0,
    FETCH_ST_HALT = 1'b1
  } fetch_state_e;

  // Wraps explicitly so a non-power-of-two memory size still lands on 0.
  function automatic logic [MEMI_SIZE_LOG-1:0] pc_next(input logic [MEMI_SIZE_LOG-1:0] pc);
    if (pc == MEMI_SIZE_LOG'(MEMI_SIZE - 1)) return '0;
    return pc + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Generic in-order synchronous FIFO with flush; push and pop together when full is allowed.
module fetch_queue #(
  parameter int DATA_W    = 40,
  parameter int DEPTH     = 4,
  parameter int DEPTH_LOG = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic                 flush_i,
  input  logic [DATA_W-1:0]    wdata_i,
  output logic [DATA_W-1:0]    rdata_o,
  output logic [DEPTH_LOG:0]   count_o
);

  logic [DATA_W-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG-1:0] head_q;
  logic [DEPTH_LOG-1:0] tail_q;
  logic [DEPTH_LOG:0]   count_q;

  // Storage carries no reset; only pointers and occupancy do.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[tail_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) tail_q <= tail_q + 1'b1;
      if (pop_i)  head_q <= head_q + 1'b1;
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC, RUN/HALT FSM, push/redirect control in front of fetch_queue.
// Optional halt-on-zero-word behaviour is enabled by defining FETCH_HALT_ON_ZERO_EN.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int FQ_DEPTH     = FQ_DEPTH_DEFAULT,
  parameter int FQ_DEPTH_LOG = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [MEMI_SIZE_LOG-1:0]  memi_req_addr,
  input  logic [INST_LEN-1:0]       memi_resp_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INST_LEN-1:0]       out_inst,
  output logic [MEMI_SIZE_LOG-1:0]  out_pc,
  input  logic                      redirect_valid,
  input  logic [MEMI_SIZE_LOG-1:0]  redirect_pc,
  output logic                      halted,
  output logic [FQ_DEPTH_LOG:0]     fq_count
);

  localparam int ENTRY_W = MEMI_SIZE_LOG + INST_LEN;

  fetch_state_e             state_q, state_d;
  logic [MEMI_SIZE_LOG-1:0] pc_q, pc_d;
  logic                     pop;
  logic                     push;
  logic                     fq_full;
  logic [ENTRY_W-1:0]       head_entry;

  // Depth is a power of two, so the count MSB alone marks a full queue.
  assign fq_full = fq_count[FQ_DEPTH_LOG];
  assign pop     = out_valid && out_ready;
  assign push    = (state_q == FETCH_ST_RUN) && !redirect_valid && (!fq_full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH_ST_RUN;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      state_d = FETCH_ST_RUN;
      pc_d    = redirect_pc;
    end else if (push) begin
`ifdef FETCH_HALT_ON_ZERO_EN
      if (memi_resp_data == '0) state_d = FETCH_ST_HALT;
      else                      pc_d    = pc_next(pc_q);
`else
      pc_d = pc_next(pc_q);
`endif
    end
  end

  fetch_queue #(
    .DATA_W    (ENTRY_W),
    .DEPTH     (FQ_DEPTH),
    .DEPTH_LOG (FQ_DEPTH_LOG)
  ) u_fq (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .wdata_i ({pc_q, memi_resp_data}),
    .rdata_o (head_entry),
    .count_o (fq_count)
  );

  assign memi_req_addr = pc_q;
  assign out_valid     = (fq_count != '0);
  assign out_pc        = head_entry[ENTRY_W-1:INST_LEN];
  assign out_inst      = head_entry[INST_LEN-1:0];

`ifdef FETCH_HALT_ON_ZERO_EN
  assign halted = (state_q == FETCH_ST_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a combinational instruction memory model.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [MEMI_SIZE_LOG-1:0] memi_req_addr;
  logic [INST_LEN-1:0]      memi_resp_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [INST_LEN-1:0]      out_inst;
  logic [MEMI_SIZE_LOG-1:0] out_pc;
  logic                     redirect_valid;
  logic [MEMI_SIZE_LOG-1:0] redirect_pc;
  logic                     halted;
  logic [2:0]               fq_count;

  logic [INST_LEN-1:0] mem [MEMI_SIZE];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign memi_resp_data = mem[memi_req_addr];

  fetch_ctrl #(.FQ_DEPTH(4), .FQ_DEPTH_LOG(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .memi_req_addr  (memi_req_addr),
    .memi_resp_data (memi_resp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .fq_count       (fq_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  function automatic logic [INST_LEN-1:0] word(input int a);
    return 32'hC0DE_0000 + INST_LEN'(a);
  endfunction

  initial begin
    for (int i = 0; i < MEMI_SIZE; i++) mem[i] = word(i);
    rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Reset state
    step(); step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_fq_count", 64'(fq_count), 64'd0);
    check("rst_addr", 64'(memi_req_addr), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);

    // Streaming: one instruction per cycle from cycle 1
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_pc", 64'(out_pc), 64'(i));
      check("stream_inst", 64'(out_inst), 64'(word(i)));
      check("stream_count", 64'(fq_count), 64'd1);
    end

    // Backpressure: fill to 4, address holds at 4, then drain in order
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) step();
    check("bp_count", 64'(fq_count), 64'd4);
    check("bp_addr", 64'(memi_req_addr), 64'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("bp_drain_valid", 64'(out_valid), 64'd1);
      check("bp_drain_pc", 64'(out_pc), 64'(i));
      check("bp_drain_inst", 64'(out_inst), 64'(word(i)));
      check("bp_drain_count", 64'(fq_count), 64'd4);
      step();
    end

    // Redirect while full with a simultaneous pop
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    check("rd_full_count", 64'(fq_count), 64'd4);
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'd6;
    check("rd_pop_valid", 64'(out_valid), 64'd1);
    check("rd_pop_pc", 64'(out_pc), 64'd0);
    step();
    redirect_valid = 1'b0;
    check("rd_flush_count", 64'(fq_count), 64'd0);
    check("rd_flush_valid", 64'(out_valid), 64'd0);
    check("rd_addr", 64'(memi_req_addr), 64'd6);
    step();
    check("rd_first_valid", 64'(out_valid), 64'd1);
    check("rd_first_pc", 64'(out_pc), 64'd6);
    check("rd_first_inst", 64'(out_inst), 64'(word(6)));
    step();
    check("rd_second_pc", 64'(out_pc), 64'd7);

    // Wrap: top address then 0
    redirect_valid = 1'b1; redirect_pc = 8'(MEMI_SIZE - 1);
    step();
    redirect_valid = 1'b0;
    check("wrap_addr", 64'(memi_req_addr), 64'(MEMI_SIZE - 1));
    check("wrap_flush_valid", 64'(out_valid), 64'd0);
    step();
    check("wrap_pc_top", 64'(out_pc), 64'(MEMI_SIZE - 1));
    check("wrap_addr_zero", 64'(memi_req_addr), 64'd0);
    step();
    check("wrap_pc_zero", 64'(out_pc), 64'd0);
    check("wrap_inst_zero", 64'(out_inst), 64'(word(0)));

    // Mid-operation reset with three entries queued
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) step();
    check("mr_count_before", 64'(fq_count), 64'd3);
    check("mr_addr_before", 64'(memi_req_addr), 64'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mr_valid", 64'(out_valid), 64'd0);
    check("mr_count", 64'(fq_count), 64'd0);
    check("mr_addr", 64'(memi_req_addr), 64'd0);
    step();
    check("mr_restart_pc", 64'(out_pc), 64'd0);
    check("mr_restart_count", 64'(fq_count), 64'd1);

`ifdef FETCH_HALT_ON_ZERO_EN
    // Halt on zero word at address 3, resume via redirect
    mem[3] = '0;
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      check("halt_pc", 64'(out_pc), 64'(i));
    end
    check("halt_zero_inst", 64'(out_inst), 64'd0);
    for (int i = 0; i < 20; i++) begin
      check("halt_flag", 64'(halted), 64'd1);
      check("halt_addr", 64'(memi_req_addr), 64'd3);
      step();
    end
    check("halt_drained", 64'(out_valid), 64'd0);
    redirect_valid = 1'b1; redirect_pc = '0;
    step();
    redirect_valid = 1'b0;
    check("halt_resume_flag", 64'(halted), 64'd0);
    check("halt_resume_addr", 64'(memi_req_addr), 64'd0);
    step();
    check("halt_resume_pc", 64'(out_pc), 64'd0);
    mem[3] = word(3);
`else
    check("no_halt_flag", 64'(halted), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
